// File: rtl/ann_result_reader_pkg.sv
// ann_result_reader_pkg: shared sizes and FSM encoding for the ANN result reader
package ann_result_reader_pkg;
  localparam int DATA_W = 16;
  localparam int WORDS_PER_ROW = 4;
  localparam int ROWS = 4;
  localparam int ADDR_W = 2;
  localparam int ROW_W = DATA_W * WORDS_PER_ROW;
  localparam int WORD_W = $clog2(WORDS_PER_ROW);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);
  typedef logic [WORDS_PER_ROW-1:0][DATA_W-1:0] row_t;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;
endpackage

// File: rtl/ann_result_reader_if.sv
// ann_result_reader_if: result memory port B plus the outgoing activation stream
interface ann_result_reader_if;
  import ann_result_reader_pkg::*;
  logic a_enb;
  logic [ADDR_W-1:0] a_addrb;
  row_t a_doutb;
  logic [DATA_W-1:0] m_tdata;
  logic m_tvalid;
  logic m_tready;
  logic m_tlast;
  modport master (
    output a_enb, a_addrb, m_tdata, m_tvalid, m_tlast,
    input  a_doutb, m_tready
  );
  modport slave (
    input  a_enb, a_addrb, m_tdata, m_tvalid, m_tlast,
    output a_doutb, m_tready
  );
endinterface

// File: rtl/ann_result_reader.sv
// ann_result_reader: drains ANN result memory row by row onto a one-word valid/ready stream
module ann_result_reader
  import ann_result_reader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic done,
  output logic busy,
  output logic overrun,
  ann_result_reader_if.master bus
);
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0] wait_q, wait_d;
  row_t row_reg_q, row_reg_d;
  logic overrun_q, overrun_d;
  logic hs;
  assign hs = (state_q == SEND) && bus.m_tready;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    word_d = word_q;
    wait_d = wait_q;
    row_reg_d = row_reg_q;
    overrun_d = done && (state_q != IDLE);
    case (state_q)
      IDLE: state_d = done ? FETCH : IDLE;
      FETCH: begin
        state_d = WAIT;
        wait_d = '0;
      end
      WAIT: begin
        wait_d = wait_q + 2'd1;
        if (wait_q == LAT_LAST) begin
          row_reg_d = bus.a_doutb;
          word_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && word_q != LAST_WORD) word_d = word_q + WORD_W'(1);
        else if (hs && row_q != LAST_ROW) begin
          row_d = row_q + ADDR_W'(1);
          state_d = FETCH;
        end else if (hs) begin
          row_d = '0;
          word_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // clr is a full abort: the stream drops without waiting for a handshake
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
      row_q <= '0;
      word_q <= '0;
      wait_q <= '0;
      row_reg_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      word_q <= word_d;
      wait_q <= wait_d;
      row_reg_q <= row_reg_d;
      overrun_q <= overrun_d;
    end
  end
  assign busy = state_q != IDLE;
  assign overrun = overrun_q;
  assign bus.a_enb = state_q == FETCH;
  assign bus.a_addrb = (state_q == FETCH) ? row_q : '0;
  assign bus.m_tvalid = state_q == SEND;
  assign bus.m_tdata = (state_q == SEND) ? row_reg_q[word_q] : '0;
  assign bus.m_tlast = (state_q == SEND) && row_q == LAST_ROW && word_q == LAST_WORD;
endmodule

// File: tb/tb_ann_result_reader.sv
// tb_ann_result_reader: scoreboard bench for the result reader at read latencies 1 and 2
module tb_ann_result_reader;
  logic clk = 1'b0;
  logic rst, clr1, done1, done2, tready1, tready2;
  logic busy1, busy2, ov1, ov2;
  logic [63:0] m1, m2a, m2b;
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  logic [16:0] e, prev_d;
  logic prev_v1, prev_r1, prev_abort;
  int total, bad, hs1, en1, en2, ovc, n, k, stall, hs_mark;
  always #5 clk = ~clk;
  ann_result_reader_if if1();
  ann_result_reader_if if2();
  ann_result_reader #(.RD_LAT(1)) u1 (.clk(clk), .rst(rst), .clr(clr1), .done(done1), .busy(busy1), .overrun(ov1), .bus(if1));
  ann_result_reader #(.RD_LAT(2)) u2 (.clk(clk), .rst(rst), .clr(1'b0), .done(done2), .busy(busy2), .overrun(ov2), .bus(if2));
  function automatic logic [63:0] row_data(input int r);
    logic [63:0] d;
    for (int w = 0; w < 4; w++) d[w*16 +: 16] = 16'(4 * r + w);
    return d;
  endfunction
  always_ff @(posedge clk) begin
    if (if1.a_enb) m1 <= row_data(int'(if1.a_addrb));
    if (if2.a_enb) m2a <= row_data(int'(if2.a_addrb));
    m2b <= m2a;
  end
  assign if1.a_doutb = m1;
  assign if2.a_doutb = m2b;
  assign if1.m_tready = tready1;
  assign if2.m_tready = tready2;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fill(input int which, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (which == 1) q1.push_back({i == 15, 16'(i)});
      else q2.push_back({i == 15, 16'(i)});
    end
  endtask
  // samples at the falling edge with this cycle's inputs already applied
  task automatic step();
    if (if1.m_tvalid && tready1) begin
      hs1++;
      if (q1.size() == 0) chk("q1_underflow", {47'b0, if1.m_tlast, if1.m_tdata}, 64'hdead);
      else begin
        e = q1.pop_front();
        chk("stream1", {47'b0, if1.m_tlast, if1.m_tdata}, {47'b0, e});
      end
    end
    if (prev_v1 && !prev_r1 && !prev_abort)
      chk("stable1", {46'b0, if1.m_tvalid, if1.m_tlast, if1.m_tdata}, {46'b0, 1'b1, prev_d});
    prev_v1 = if1.m_tvalid;
    prev_r1 = tready1;
    prev_d = {if1.m_tlast, if1.m_tdata};
    prev_abort = clr1 || rst;
    if (ov1) ovc++;
    if (if1.a_enb) en1++;
    if (if2.a_enb) begin
      chk("addr2", {62'b0, if2.a_addrb}, 64'(en2));
      en2++;
    end
    if (if2.m_tvalid && tready2) begin
      if (q2.size() == 0) chk("q2_underflow", {47'b0, if2.m_tlast, if2.m_tdata}, 64'hdead);
      else begin
        e = q2.pop_front();
        chk("stream2", {47'b0, if2.m_tlast, if2.m_tdata}, {47'b0, e});
      end
    end
    @(negedge clk);
  endtask
  // mode 0: ready high; mode 1: ready pattern with stalls; mode 2: extra done pulses
  task automatic drain(input int mode, output int cnt);
    cnt = 0;
    k = 0;
    stall = 0;
    while (busy1 && cnt < 200) begin
      cnt++;
      tready1 = 1'b1;
      if (mode == 1 && if1.m_tvalid) begin
        if (k < 4) tready1 = (k % 2 == 0);
        else if (if1.m_tdata == 16'h6 && stall < 5) begin
          tready1 = 1'b0;
          stall++;
        end
        k++;
      end
      done1 = (mode == 2) && (cnt == 3 || (if1.m_tlast && if1.m_tvalid && tready1));
      step();
    end
    done1 = 1'b0;
    tready1 = 1'b1;
  endtask
  initial begin
    total = 0; bad = 0; hs1 = 0; en1 = 0; en2 = 0; ovc = 0;
    prev_v1 = 0; prev_r1 = 0; prev_abort = 1; prev_d = '0;
    rst = 1; clr1 = 0; done1 = 0; done2 = 0; tready1 = 1; tready2 = 1;
    @(negedge clk);
    step();
    step();
    chk("rst_tvalid", {63'b0, if1.m_tvalid}, 64'd0);
    chk("rst_busy", {63'b0, busy1}, 64'd0);
    chk("rst_enb", {63'b0, if1.a_enb}, 64'd0);
    chk("rst_addr", {62'b0, if1.a_addrb}, 64'd0);
    chk("rst_tlast", {63'b0, if1.m_tlast}, 64'd0);
    chk("rst_tdata", {48'b0, if1.m_tdata}, 64'd0);
    chk("rst_overrun", {63'b0, ov1}, 64'd0);
    done1 = 1; done2 = 1;
    step();
    done1 = 0; done2 = 0;
    for (int i = 0; i < 4; i++) step();
    chk("rstdone_enb", 64'(en1 + en2), 64'd0);
    chk("rstdone_busy", {62'b0, busy1, busy2}, 64'd0);
    chk("rstdone_hs", 64'(hs1), 64'd0);
    rst = 0;
    step();
    fill(1, 16);
    done1 = 1;
    step();
    done1 = 0;
    drain(0, n);
    chk("t1_busy_cycles", 64'(n), 64'd24);
    chk("t1_q_empty", 64'(q1.size()), 64'd0);
    chk("t1_enb_count", 64'(en1), 64'd4);
    step();
    fill(1, 16);
    done1 = 1;
    step();
    done1 = 0;
    drain(1, n);
    chk("t2_q_empty", 64'(q1.size()), 64'd0);
    chk("t2_stalls", 64'(stall), 64'd5);
    step();
    fill(1, 16);
    ovc = 0;
    done1 = 1;
    step();
    done1 = 0;
    drain(2, n);
    hs_mark = hs1;
    for (int i = 0; i < 5; i++) step();
    chk("t3_busy_cycles", 64'(n), 64'd24);
    chk("t3_overruns", 64'(ovc), 64'd2);
    chk("t3_no_restart", {63'b0, busy1}, 64'd0);
    chk("t3_no_extra_hs", 64'(hs1 - hs_mark), 64'd0);
    chk("t3_q_empty", 64'(q1.size()), 64'd0);
    fill(1, 6);
    hs_mark = hs1;
    done1 = 1;
    step();
    done1 = 0;
    for (int i = 0; i < 100 && hs1 - hs_mark < 6; i++) step();
    chk("t4_hs_before_clr", 64'(hs1 - hs_mark), 64'd6);
    clr1 = 1;
    tready1 = 0;
    step();
    clr1 = 0;
    tready1 = 1;
    chk("t4_tvalid_after_clr", {63'b0, if1.m_tvalid}, 64'd0);
    chk("t4_busy_after_clr", {63'b0, busy1}, 64'd0);
    step();
    fill(1, 16);
    done1 = 1;
    step();
    done1 = 0;
    drain(0, n);
    chk("t4_restart_cycles", 64'(n), 64'd24);
    chk("t4_q_empty", 64'(q1.size()), 64'd0);
    fill(2, 16);
    done2 = 1;
    step();
    done2 = 0;
    n = 0;
    while (busy2 && n < 200) begin
      n++;
      step();
    end
    chk("t5_busy_cycles", 64'(n), 64'd28);
    chk("t5_enb_count", 64'(en2), 64'd4);
    chk("t5_q_empty", 64'(q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
